shared_ram_arb: RTL and testbench

//  Arbitrates the single-port 2Kx8 sound/main shared RAM between the M68K (window 0x600000-0x600FFF, low byte only)
//  and the sound Z80 (0x8000-0x87FF). Consumes shared_ram_cs from the chip-select decode; returns M68K DTACK and

---
 rtl/shared_ram_arb_pkg.sv | 23 ++
 rtl/shared_ram_arb.sv | 211 +++++++++++++++++++++
 tb/tb_shared_ram_arb.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// shared_ram_arb_pkg : window geometry, RAM latency and FSM state type shared
//                      by the M68K/Z80 shared-RAM arbiter.
// Rev 1.0
// ============================================================================
package shared_ram_arb_pkg;

    localparam int          C_AW         = 11;
    localparam logic [15:0] C_Z80_BASE   = 16'h8000;
    localparam logic [1:0]  C_RAM_RD_LAT = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_Z_RD  = 3'd1,
        ST_Z_WR  = 3'd2,
        ST_M_RD  = 3'd3,
        ST_M_WR  = 3'd4,
        ST_M_ACK = 3'd5
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/shared_ram_arb.sv
`default_nettype none
// ============================================================================
// shared_ram_arb : single-port 2Kx8 shared RAM arbiter, Z80 priority over M68K.
//                  Optional Z80 WAIT generation under SHARED_RAM_WAIT_EN.
// Rev 1.0
// ============================================================================
module shared_ram_arb
    import shared_ram_arb_pkg::*;
#(
    parameter int          AW       = C_AW,
    parameter logic [15:0] Z80_BASE = C_Z80_BASE
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          shared_ram_cs,
    input  logic [AW-1:0] cpu_a,
    input  logic          cpu_rw,
    input  logic          cpu_lds_n,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_dtack_n,
    input  logic [15:0]   z80_addr,
    input  logic          MREQ_n,
    input  logic          RD_n,
    input  logic          WR_n,
    input  logic [7:0]    z80_din,
    output logic [7:0]    z80_dout,
    output logic          z80_ram_cs,
    output logic          z80_wait_n,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata
);

    arb_state_e    state_q,       state_d;
    logic          z_req_q;
    logic          z_pend_q,      z_pend_d;
    logic [AW-1:0] z_addr_q,      z_addr_d;
    logic [7:0]    z_data_q,      z_data_d;
    logic          z_wr_q,        z_wr_d;
    logic [1:0]    lat_cnt_q,     lat_cnt_d;
    logic          m_done_q,      m_done_d;
    logic [7:0]    cpu_dout_q,    cpu_dout_d;
    logic          cpu_dtack_n_q, cpu_dtack_n_d;
    logic [7:0]    z80_dout_q,    z80_dout_d;
    logic [AW-1:0] ram_addr_q,    ram_addr_d;
    logic          ram_we_q,      ram_we_d;
    logic [7:0]    ram_wdata_q,   ram_wdata_d;

    logic          z_req;
    logic          z_rise;
    logic          m_req;
    logic [AW-1:0] z_svc_addr;
    logic [7:0]    z_svc_data;
    logic          z_svc_wr;

    assign z80_ram_cs = !MREQ_n && (z80_addr[15:AW] == Z80_BASE[15:AW]);
    assign z_req      = z80_ram_cs && (!RD_n || !WR_n);
    assign z_rise     = z_req && !z_req_q;
    assign m_req      = shared_ram_cs && (state_q == ST_IDLE) && !m_done_q;

    // A Z80 edge arriving in IDLE is served straight from the bus so it still
    // beats an M68K request raised in the same clock.
    assign z_svc_addr = z_rise ? z80_addr[AW-1:0] : z_addr_q;
    assign z_svc_data = z_rise ? z80_din          : z_data_q;
    assign z_svc_wr   = z_rise ? !WR_n            : z_wr_q;

    always_comb begin
        state_d       = state_q;
        z_pend_d      = z_pend_q;
        z_addr_d      = z_addr_q;
        z_data_d      = z_data_q;
        z_wr_d        = z_wr_q;
        lat_cnt_d     = lat_cnt_q;
        m_done_d      = m_done_q;
        cpu_dout_d    = cpu_dout_q;
        cpu_dtack_n_d = cpu_dtack_n_q;
        z80_dout_d    = z80_dout_q;
        ram_addr_d    = ram_addr_q;
        ram_we_d      = 1'b0;
        ram_wdata_d   = ram_wdata_q;

        if (z_rise) begin
            z_pend_d = 1'b1;
            z_addr_d = z80_addr[AW-1:0];
            z_data_d = z80_din;
            z_wr_d   = !WR_n;
        end

        case (state_q)
            ST_IDLE: begin
                if (z_pend_q || z_rise) begin
                    ram_addr_d = z_svc_addr;
                    lat_cnt_d  = 2'd0;
                    if (z_svc_wr) begin
                        state_d     = ST_Z_WR;
                        ram_we_d    = 1'b1;
                        ram_wdata_d = z_svc_data;
                    end else begin
                        state_d = ST_Z_RD;
                    end
                end else if (m_req) begin
                    ram_addr_d = cpu_a;
                    lat_cnt_d  = 2'd0;
                    if (cpu_lds_n) begin
                        // Upper-byte-only access: acknowledge without touching RAM.
                        state_d       = ST_M_ACK;
                        cpu_dout_d    = 8'hFF;
                        cpu_dtack_n_d = 1'b0;
                        m_done_d      = 1'b1;
                    end else if (cpu_rw) begin
                        state_d = ST_M_RD;
                    end else begin
                        state_d     = ST_M_WR;
                        ram_we_d    = 1'b1;
                        ram_wdata_d = cpu_din;
                    end
                end
            end
            ST_Z_RD: begin
                if (lat_cnt_q == C_RAM_RD_LAT) begin
                    z80_dout_d = ram_rdata;
                    z_pend_d   = z_rise;
                    state_d    = ST_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_Z_WR: begin
                z_pend_d = z_rise;
                state_d  = ST_IDLE;
            end
            ST_M_RD: begin
                if (lat_cnt_q == C_RAM_RD_LAT) begin
                    cpu_dout_d    = ram_rdata;
                    cpu_dtack_n_d = 1'b0;
                    m_done_d      = 1'b1;
                    state_d       = ST_M_ACK;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_M_WR: begin
                cpu_dtack_n_d = 1'b0;
                m_done_d      = 1'b1;
                state_d       = ST_M_ACK;
            end
            ST_M_ACK: begin
                if (!shared_ram_cs) begin
                    cpu_dtack_n_d = 1'b1;
                    m_done_d      = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            z_req_q       <= 1'b0;
            z_pend_q      <= 1'b0;
            z_addr_q      <= '0;
            z_data_q      <= 8'h00;
            z_wr_q        <= 1'b0;
            lat_cnt_q     <= 2'd0;
            m_done_q      <= 1'b0;
            cpu_dout_q    <= 8'h00;
            cpu_dtack_n_q <= 1'b1;
            z80_dout_q    <= 8'h00;
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            z_req_q       <= z_req;
            z_pend_q      <= z_pend_d;
            z_addr_q      <= z_addr_d;
            z_data_q      <= z_data_d;
            z_wr_q        <= z_wr_d;
            lat_cnt_q     <= lat_cnt_d;
            m_done_q      <= m_done_d;
            cpu_dout_q    <= cpu_dout_d;
            cpu_dtack_n_q <= cpu_dtack_n_d;
            z80_dout_q    <= z80_dout_d;
            ram_addr_q    <= ram_addr_d;
            ram_we_q      <= ram_we_d;
            ram_wdata_q   <= ram_wdata_d;
        end
    end

    assign cpu_dout    = cpu_dout_q;
    assign cpu_dtack_n = cpu_dtack_n_q;
    assign z80_dout    = z80_dout_q;
    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;

`ifdef SHARED_RAM_WAIT_EN
    // z_pend clears on the same edge z80_dout loads, releasing WAIT with the data.
    assign z80_wait_n = !(z_pend_q && !z_wr_q);
`else
    assign z80_wait_n = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shared_ram_arb.sv
`default_nettype none
// ============================================================================
// tb_shared_ram_arb : randomized self-checking bench for shared_ram_arb against
//                     a transaction-level memory model.
// Rev 1.0
// ============================================================================
module tb_shared_ram_arb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        shared_ram_cs = 1'b0;
    logic [10:0] cpu_a = '0;
    logic        cpu_rw = 1'b1;
    logic        cpu_lds_n = 1'b1;
    logic [7:0]  cpu_din = 8'h00;
    logic [7:0]  cpu_dout;
    logic        cpu_dtack_n;
    logic [15:0] z80_addr = 16'h0000;
    logic        MREQ_n = 1'b1;
    logic        RD_n = 1'b1;
    logic        WR_n = 1'b1;
    logic [7:0]  z80_din = 8'h00;
    logic [7:0]  z80_dout;
    logic        z80_ram_cs;
    logic        z80_wait_n;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    always #5 clk = ~clk;

    shared_ram_arb dut (
        .clk(clk), .reset_n(reset_n), .shared_ram_cs(shared_ram_cs), .cpu_a(cpu_a),
        .cpu_rw(cpu_rw), .cpu_lds_n(cpu_lds_n), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_dtack_n(cpu_dtack_n), .z80_addr(z80_addr), .MREQ_n(MREQ_n), .RD_n(RD_n),
        .WR_n(WR_n), .z80_din(z80_din), .z80_dout(z80_dout), .z80_ram_cs(z80_ram_cs),
        .z80_wait_n(z80_wait_n), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Physical synchronous RAM, plus a bulk-load port and a backdoor poke port.
    logic [7:0]  ram_mem  [0:2047];
    logic [7:0]  init_mem [0:2047];
    logic [7:0]  rdata_r;
    logic        init_req = 1'b0;
    logic        bd_req = 1'b0;
    logic [10:0] bd_addr = '0;
    logic [7:0]  bd_data = 8'h00;
    int          we_count = 0;
    logic [10:0] last_we_addr = '0;
    logic [7:0]  last_we_data = 8'h00;

    always @(posedge clk) begin
        rdata_r <= ram_mem[ram_addr];
        if (init_req) begin
            for (int i = 0; i < 2048; i++) ram_mem[i] <= init_mem[i];
        end
        if (bd_req) ram_mem[bd_addr] <= bd_data;
        if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
            we_count          <= we_count + 1;
            last_we_addr      <= ram_addr;
            last_we_data      <= ram_wdata;
        end
    end
    assign ram_rdata = rdata_r;

    // Reference model: contents the RAM must hold after each completed transaction.
    logic [7:0] ref_mem [0:2047];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [7:0] m_dout;
    int         m_lat;
    int         m_rel;

    task automatic m68k_op(input logic [10:0] a, input logic rw, input logic lds,
                           input logic [7:0] d);
        @(negedge clk);
        shared_ram_cs = 1'b1; cpu_a = a; cpu_rw = rw; cpu_lds_n = lds; cpu_din = d;
        m_lat = 0;
        do begin @(posedge clk); #1; m_lat++; end while (cpu_dtack_n && m_lat < 20);
        check_val("m_dtack_seen", {31'd0, cpu_dtack_n}, 32'd0);
        m_dout = cpu_dout;
        @(negedge clk);
        shared_ram_cs = 1'b0; cpu_lds_n = 1'b1;
        m_rel = 0;
        do begin @(posedge clk); #1; m_rel++; end while (!cpu_dtack_n && m_rel < 20);
    endtask

    task automatic z80_op(input logic [15:0] a, input logic wr, input logic [7:0] d, input int hold);
        @(negedge clk);
        z80_addr = a; z80_din = d; MREQ_n = 1'b0; RD_n = wr; WR_n = !wr;
        @(posedge clk); #1;
        if (!wr) begin
`ifdef SHARED_RAM_WAIT_EN
            check_val("z_wait_low", {31'd0, z80_wait_n}, 32'd0);
`else
            check_val("z_wait_tied", {31'd0, z80_wait_n}, 32'd1);
`endif
        end
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        MREQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    endtask

    task automatic poke(input logic [10:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_addr = a; bd_data = d; bd_req = 1'b1;
        @(negedge clk);
        bd_req = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_dtack"},  {31'd0, cpu_dtack_n}, 32'd1);
        check_val({tag, "_we"},     {31'd0, ram_we},      32'd0);
        check_val({tag, "_cpudo"},  {24'd0, cpu_dout},    32'd0);
        check_val({tag, "_z80do"},  {24'd0, z80_dout},    32'd0);
        check_val({tag, "_raddr"},  {21'd0, ram_addr},    32'd0);
        check_val({tag, "_wait"},   {31'd0, z80_wait_n},  32'd1);
    endtask

    initial begin
        int         w0;
        int         op;
        logic [10:0] a, za, ma;
        logic [7:0]  d, zd, md, v, nv, zexp, mexp;
        logic        zwr, mrw;

        #3 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_state("rst");

        for (int i = 0; i < 2048; i++) begin
            init_mem[i] = 8'($urandom);
            ref_mem[i]  = init_mem[i];
        end
        init_mem[8] = 8'h5A;
        ref_mem[8]  = 8'h5A;
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // M68K read at 0x600010 -> RAM byte 8
        w0 = we_count;
        m68k_op(11'h008, 1'b1, 1'b0, 8'h00);
        check_val("m_rd_data",  {24'd0, m_dout}, 32'h5A);
        check_val("m_rd_lat",   {31'd0, m_lat <= 3}, 32'd1);
        check_val("m_rd_rel",   m_rel, 32'd1);
        check_val("m_rd_nowe",  we_count - w0, 32'd0);

        // M68K write at 0x600FFE, then Z80 read 0x87FF
        w0 = we_count;
        m68k_op(11'h7FF, 1'b0, 1'b0, 8'hC3);
        ref_mem[11'h7FF] = 8'hC3;
        check_val("m_wr_pulses", we_count - w0, 32'd1);
        check_val("m_wr_addr",   {21'd0, last_we_addr}, 32'h7FF);
        check_val("m_wr_data",   {24'd0, last_we_data}, 32'hC3);
        check_val("m_wr_lat",    {31'd0, m_lat <= 3}, 32'd1);
        z80_op(16'h87FF, 1'b0, 8'h00, 8);
        check_val("z_rd_top", {24'd0, z80_dout}, 32'hC3);

        // Upper-byte-only access
        w0 = we_count;
        m68k_op(11'h123, 1'b1, 1'b1, 8'h00);
        check_val("m_lds_dout", {24'd0, m_dout}, 32'hFF);
        check_val("m_lds_lat",  {31'd0, m_lat <= 2}, 32'd1);
        check_val("m_lds_nowe", we_count - w0, 32'd0);

        // Same-clock Z80 write and M68K read of byte 5: Z80 first
        fork
            z80_op(16'h8005, 1'b1, 8'h11, 8);
            m68k_op(11'h005, 1'b1, 1'b0, 8'h00);
        join
        ref_mem[5] = 8'h11;
        check_val("prio_m_rd", {24'd0, m_dout}, 32'h11);

        // RD held 8 clocks: exactly one service, later RAM change must not leak
        v  = ref_mem[11'h010];
        nv = ~v;
        w0 = we_count;
        fork
            z80_op(16'h8010, 1'b0, 8'h00, 8);
            begin repeat (5) @(posedge clk); poke(11'h010, nv); end
        join
        ref_mem[11'h010] = nv;
        check_val("z_hold_once", {24'd0, z80_dout}, {24'd0, v});
        check_val("z_hold_nowe", we_count - w0, 32'd0);
        z80_op(16'h8010, 1'b0, 8'h00, 8);
        check_val("z_new_cycle", {24'd0, z80_dout}, {24'd0, nv});

        @(negedge clk);
        z80_addr = 16'h8800; MREQ_n = 1'b0;
        #1 check_val("zcs_out", {31'd0, z80_ram_cs}, 32'd0);
        z80_addr = 16'h87FF;
        #1 check_val("zcs_in",  {31'd0, z80_ram_cs}, 32'd1);
        MREQ_n = 1'b1;

        // Reset in the middle of an M68K read with a Z80 write pending
        @(negedge clk);
        shared_ram_cs = 1'b1; cpu_a = 11'h020; cpu_rw = 1'b1; cpu_lds_n = 1'b0;
        @(negedge clk);
        z80_addr = 16'h8021; z80_din = 8'hEE; MREQ_n = 1'b0; WR_n = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1 check_reset_state("mid_rst");
        @(negedge clk);
        shared_ram_cs = 1'b0; cpu_lds_n = 1'b1; MREQ_n = 1'b1; WR_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        w0 = we_count;
        repeat (6) @(posedge clk);
        #1 check_val("mid_rst_nopend", we_count - w0, 32'd0);

        // Randomized transactions against the memory model
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 5));
            a  = 11'($urandom);
            d  = 8'($urandom);
            w0 = we_count;
            case (op)
                0: begin
                    m68k_op(a, 1'b1, 1'b0, 8'h00);
                    check_val("r_m_rd", {24'd0, m_dout}, {24'd0, ref_mem[a]});
                    check_val("r_m_rd_lat", {31'd0, m_lat <= 3}, 32'd1);
                end
                1: begin
                    m68k_op(a, 1'b0, 1'b0, d);
                    ref_mem[a] = d;
                    check_val("r_m_wr_addr", {21'd0, last_we_addr}, {21'd0, a});
                    check_val("r_m_wr_data", {24'd0, last_we_data}, {24'd0, d});
                end
                2: begin
                    m68k_op(a, $urandom_range(0, 1) == 1, 1'b1, d);
                    check_val("r_m_lds", {24'd0, m_dout}, 32'hFF);
                end
                3: begin
                    z80_op({5'b10000, a}, 1'b0, 8'h00, 8);
                    check_val("r_z_rd", {24'd0, z80_dout}, {24'd0, ref_mem[a]});
                end
                4: begin
                    z80_op({5'b10000, a}, 1'b1, d, 8);
                    ref_mem[a] = d;
                end
                default: begin
                    zwr = 1'($urandom);
                    mrw = 1'($urandom);
                    za  = a;
                    ma  = ($urandom_range(0, 1) == 1) ? za : 11'($urandom);
                    zd  = d;
                    md  = 8'($urandom);
                    zexp = ref_mem[za];
                    if (zwr) ref_mem[za] = zd;
                    mexp = ref_mem[ma];
                    if (!mrw) ref_mem[ma] = md;
                    fork
                        z80_op({5'b10000, za}, zwr, zd, 8);
                        m68k_op(ma, mrw, 1'b0, md);
                    join
                    if (!zwr) check_val("r_c_z_rd", {24'd0, z80_dout}, {24'd0, zexp});
                    if (mrw)  check_val("r_c_m_rd", {24'd0, m_dout},   {24'd0, mexp});
                end
            endcase
            @(posedge clk); #1;
            check_val("r_we_count", we_count - w0,
                      (op == 1 || op == 4) ? 32'd1 :
                      (op == 5) ? {31'd0, zwr} + {31'd0, !mrw} : 32'd0);
        end

        // Final sweep of a few random locations through the Z80 port
        for (int k = 0; k < 6; k++) begin
            a = 11'($urandom);
            z80_op({5'b10000, a}, 1'b0, 8'h00, 6);
            check_val("sweep_z_rd", {24'd0, z80_dout}, {24'd0, ref_mem[a]});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
